// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter (start, NB_DATA bits LSB-first, optional parity, NB_STOP stops),
// bit timing from an oversampling tick. Parity logic is built only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int NB_STOP    = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic [1:0]         i_parity_mode,
  output logic               o_tx,
  output logic               o_tx_ready,
  output logic               o_tx_busy,
  output logic               o_tx_done,
  output logic [2:0]         o_dbg_state
);
  localparam int NB_TICK = $clog2(OVERSAMPLE);
  localparam int NB_BIT  = $clog2(NB_DATA);
  localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(OVERSAMPLE - 1);
  localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_DATA - 1);
  localparam logic               STOP_LAST = 1'(NB_STOP - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NB_TICK-1:0]   tick_q, tick_d;
  logic [NB_BIT-1:0]    bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [NB_DATA-1:0]   shift_q, shift_d;
  logic                 tx_d, done_d, bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d, par_bit_q, par_bit_d;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^i_parity_mode;
`endif

  // Handshake: i_tx_start is a request that transfers only in a cycle where o_tx_ready is high;
  // requests seen while busy are dropped, never queued.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    bit_end = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    if (i_tick) begin
      if (tick_q == TICK_LAST) begin
        tick_d  = '0;
        bit_end = 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // A tick in the accept cycle must not count toward the start bit.
        tick_d = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (i_tx_start) begin
          shift_d = i_tx_data;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_en_d  = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
          par_bit_d = (i_parity_mode == 2'b10) ? ~^i_tx_data : ^i_tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            stop_d  = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
        stop_d  = 1'b0;
      end
    endcase

    // o_tx is registered from the bit value of the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_bit_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      o_tx      <= tx_d;
      o_tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign o_tx_ready  = (state_q == IDLE);
  assign o_tx_busy   = ~o_tx_ready;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: one-stop and two-stop instances on a shared tick (every 4 clocks),
// frames compared bit-by-bit against a frame model built from the word, parity mode and stop count.
module tb_uart_tx_cfg;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_tick = 1'b0;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [7:0] i_tx_data = '0;
  logic [1:0] i_parity_mode = '0;
  logic       tx1, ready1, busy1, done1, tx2, ready2, busy2, done2;
  logic [2:0] st1, st2;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;

  uart_tx_cfg #(.NB_DATA(8), .NB_STOP(1), .OVERSAMPLE(OS)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(start1),
    .i_tx_data(i_tx_data), .i_parity_mode(i_parity_mode), .o_tx(tx1),
    .o_tx_ready(ready1), .o_tx_busy(busy1), .o_tx_done(done1), .o_dbg_state(st1));

  uart_tx_cfg #(.NB_DATA(8), .NB_STOP(2), .OVERSAMPLE(OS)) dut2 (
    .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_tx_start(start2),
    .i_tx_data(i_tx_data), .i_parity_mode(i_parity_mode), .o_tx(tx2),
    .o_tx_ready(ready2), .o_tx_busy(busy2), .o_tx_done(done2), .o_dbg_state(st2));

  // clock / reset / tick
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick_cnt = tick_cnt + 1;
      i_tick = (tick_cnt % 4 == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic bit parity_on(input logic [1:0] m);
`ifdef UART_TX_PARITY_EN
    return (m == 2'b01) || (m == 2'b10);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic parity_value(input logic [7:0] d, input logic [1:0] m);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (m == 2'b01) ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  // {tx, busy, ready, done} of the selected instance
  function automatic logic [3:0] obs(input int sel);
    return (sel != 0) ? {tx2, busy2, ready2, done2} : {tx1, busy1, ready1, done1};
  endfunction

  // driver tasks
  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start2 = v; else start1 = v;
  endtask

  task automatic wait_ready(input int sel);
    int n = 0;
    logic [3:0] o;
    o = obs(sel);
    while (!o[1] && n < 3000) begin
      @(posedge clk); #1;
      o = obs(sel);
      n++;
    end
    checks++;
    if (!o[1]) begin
      errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", o[1], n);
    end
  endtask

  task automatic request(input int sel, input logic [7:0] d, input logic [1:0] m);
    wait_ready(sel);
    i_tx_data = d;
    i_parity_mode = m;
    set_start(sel, 1'b1);
  endtask

  // Called with a request already driven; the next edge is the accept edge.
  task automatic check_frame(input int sel, input logic [7:0] d, input logic [1:0] m,
                             input string name, input bit keep_start,
                             input logic [7:0] next_data, input int inject_at);
    logic [0:0] exp_q[$];
    logic [3:0] o;
    int total, ticks, glitches, k;
    bit tk, seen_done, pulse_on, injected;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (parity_on(m)) exp_q.push_back(parity_value(d, m));
    for (int s = 0; s < ((sel != 0) ? 2 : 1); s++) exp_q.push_back(1'b1);
    total = exp_q.size() * OS;

    @(posedge clk); #1;
    o = obs(sel);
    checks++;
    if (o[3] !== 1'b0 || o[2] !== 1'b1 || o[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_latency: tx/busy/done=%b%b%b, required 010", name, o[3], o[2], o[0]);
    end
    if (keep_start) i_tx_data = next_data;
    else set_start(sel, 1'b0);

    ticks = 0; glitches = 0; seen_done = 0; pulse_on = 0; injected = 0;
    for (int cyc = 0; cyc < total * 8 && !seen_done; cyc++) begin
      @(posedge clk);
      tk = i_tick;
      #1;
      o = obs(sel);
      if (pulse_on) begin
        set_start(sel, 1'b0);
        pulse_on = 0;
      end
      if (tk) ticks++;
      if (ticks == total) begin
        seen_done = 1;
        checks++;
        if (o[0] !== 1'b1 || o[3] !== 1'b1 || o[1] !== 1'b1) begin
          errors++;
          $display("FAIL %s frame_end: done/tx/ready=%b%b%b after %0d ticks, required 111",
                   name, o[0], o[3], o[1], ticks);
        end
      end else begin
        if (o[3] !== exp_q[ticks / OS] || o[2] !== 1'b1 || o[0] !== 1'b0) glitches++;
        if (tk && (ticks % OS) == OS / 2) begin
          k = ticks / OS;
          checks++;
          if (o[3] !== exp_q[k]) begin
            errors++;
            $display("FAIL %s bit%0d: tx=%b, required %b", name, k, o[3], exp_q[k]);
          end
        end
        if (inject_at >= 0 && ticks == inject_at && !injected) begin
          i_tx_data = 8'h12;
          set_start(sel, 1'b1);
          injected = 1;
          pulse_on = 1;
        end
      end
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s timeout: %0d ticks seen, required %0d", name, ticks, total);
    end
    checks++;
    if (glitches != 0) begin
      errors++;
      $display("FAIL %s line_profile: %0d bad cycles, required 0", name, glitches);
    end
    if (!keep_start) begin
      @(posedge clk); #1;
      o = obs(sel);
      checks++;
      if (o[0] !== 1'b0 || o[3] !== 1'b1 || o[1] !== 1'b1) begin
        errors++;
        $display("FAIL %s after_done: done/tx/ready=%b%b%b, required 011", name, o[0], o[3], o[1]);
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    logic [3:0] o;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      checks++;
      if (o !== 4'b1010) begin
        errors++;
        $display("FAIL reset_values dut%0d: tx/busy/ready/done=%b, required 1010", s + 1, o);
      end
    end
    @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = obs(0);
    checks++;
    if (o !== 4'b1010) begin
      errors++;
      $display("FAIL idle_after_reset: tx/busy/ready/done=%b, required 1010", o);
    end
  endtask

  task automatic test_pattern_55();
    request(0, 8'h55, 2'b00);
    check_frame(0, 8'h55, 2'b00, "pattern_55", 0, 8'h00, -1);
  endtask

  task automatic test_parity();
    logic [1:0] modes[3];
    modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      request(0, 8'h07, modes[i]);
      check_frame(0, 8'h07, modes[i], $sformatf("parity_m%0d", modes[i]), 0, 8'h00, -1);
    end
  endtask

  task automatic test_two_stop();
    request(1, 8'hFF, 2'b00);
    check_frame(1, 8'hFF, 2'b00, "two_stop", 0, 8'h00, -1);
  endtask

  task automatic test_ignore_busy();
    request(0, 8'hA5, 2'b00);
    check_frame(0, 8'hA5, 2'b00, "ignore_busy", 0, 8'h00, 5 * OS + 3);
  endtask

  task automatic test_back_to_back();
    request(0, 8'h3C, 2'b00);
    check_frame(0, 8'h3C, 2'b00, "b2b_first", 1, 8'hC3, -1);
    check_frame(0, 8'hC3, 2'b00, "b2b_second", 0, 8'h00, -1);
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] o;
    int ticks = 0;
    bit tk, done_seen = 0;
    request(0, 8'hF0, 2'b00);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    for (int cyc = 0; cyc < 2000 && ticks < 4 * OS + OS / 2; cyc++) begin
      @(posedge clk);
      tk = i_tick;
      #1;
      if (tk) ticks++;
    end
    o = obs(0);
    checks++;
    if (o[3] !== 1'b0 || o[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_bit3: tx/busy=%b%b, required 01", o[3], o[2]);
    end
    i_reset = 1'b1;
    #1;
    o = obs(0);
    checks++;
    if (o !== 4'b1010) begin
      errors++;
      $display("FAIL reset_abort: tx/busy/ready/done=%b, required 1010", o);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0) done_seen = 1;
    end
    @(negedge clk);
    i_reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0) done_seen = 1;
    end
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL reset_no_done: done pulse seen=1, required 0");
    end
    request(0, 8'h81, 2'b00);
    check_frame(0, 8'h81, 2'b00, "after_reset_81", 0, 8'h00, -1);
  endtask

  task automatic test_random();
    int sel;
    logic [7:0] d;
    logic [1:0] m;
    for (int r = 0; r < 6; r++) begin
      sel = $urandom_range(0, 1);
      d = 8'($urandom_range(0, 255));
      m = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 7)) @(posedge clk);
      #1;
      request(sel, d, m);
      check_frame(sel, d, m, $sformatf("rand%0d_d%02h_m%0d_s%0d", r, d, m, sel), 0, 8'h00, -1);
    end
  endtask

  initial begin
    test_reset();
    test_pattern_55();
    test_parity();
    test_two_stop();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter that serialises one data word per frame: start bit, NB_DATA data bits LSB-first, an optional parity bit, then NB_STOP stop bits. Bit timing comes from the shared baud-rate tick generator through i_tick, oversampled OVERSAMPLE times per bit. It sits between the interface/FIFO logic and the serial pin. It adds a ready/busy handshake, runtime parity selection, configurable oversampling and back-to-back frame support.

## Interface
- NB_DATA, 8: data bits per frame; legal range 5..9.
- NB_STOP, 1: stop bits; legal values 1 or 2.
- OVERSAMPLE, 16: i_tick pulses per bit period; legal range 4..64.
- NB_TICK, $clog2(OVERSAMPLE): width of the tick counter (localparam).
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_tick  in  1  oversample tick, one-cycle pulse from the baud generator.
- i_tx_start  in  1  frame request; accepted only while o_tx_ready=1.
- i_tx_data  in  NB_DATA  word to send; sampled on the accept cycle.
- i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; sampled on the accept cycle.
- o_tx  out  1  serial line, registered; idles high.
- o_tx_ready  out  1  high in IDLE; the block can accept a frame.
- o_tx_busy  out  1  inverse of o_tx_ready.
- o_tx_done  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept = i_tx_start & o_tx_ready.
  - On accept, latch data and parity mode into a shift register.
  - Clear the tick counter and the bit counter, then go to START.
  - i_tx_start while busy is ignored. Nothing is queued.
- o_tx drives the current state's bit value:
  - IDLE: 1.
  - START: 0.
  - DATA: shift[0].
  - PARITY: the parity bit.
  - STOP: 1.
- Tick counter:
  - Increments on i_tick.
  - On i_tick with count == OVERSAMPLE-1, it wraps to 0 and the bit ends.
  - Bit-end actions by state:
    - START goes to DATA.
    - DATA shifts right and increments the bit counter. After bit NB_DATA-1 it goes to PARITY when the mode is 01/10, otherwise to STOP.
    - PARITY goes to STOP.
    - STOP increments the stop counter. After stop bit NB_STOP-1 it goes to IDLE and pulses o_tx_done.
- Parity is computed from the latched word:
  - even: parity bit = ^data.
  - odd: parity bit = ~^data.
- Cycles without i_tick hold all state.
- Illegal state returns to IDLE with o_tx=1.

## Timing
- Reset values:
  - o_tx=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0.
  - state IDLE; counters 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronously), with outputs at their reset values. No o_tx_done pulse is produced.
- Latency: o_tx falls on the first clock edge after the accept cycle (registered output).
- Each bit lasts exactly OVERSAMPLE i_tick pulses.
- Frame length = (1 + NB_DATA + P + NB_STOP) × OVERSAMPLE ticks, where P = 1 when parity is enabled.
- o_tx_done, o_tx_ready=1 and state IDLE are all registered on the same edge that ends the last stop bit.
- Back-to-back:
  - i_tx_start held high in that same cycle is accepted.
  - The next start bit begins one clock later, so the line never idles for a full bit.
- i_tick coincident with accept is not counted toward the start bit.

## Configuration
- UART_TX_PARITY_EN defined:
  - i_parity_mode is honoured.
  - The PARITY state and the parity logic are built.
- UART_TX_PARITY_EN undefined:
  - The port still exists but is ignored.
  - The PARITY state is not generated; frames are always N (no parity).
  - Frame length = (1 + NB_DATA + NB_STOP) × OVERSAMPLE.

## Test plan
All scenarios use OVERSAMPLE=16 and i_tick every 4 clocks unless noted.
- NB_DATA=8, NB_STOP=1, mode 00, data 0x55 → o_tx bits 0,1,0,1,0,1,0,1,0,1, each 16 ticks wide; o_tx_done once, after 160 ticks.
- Macro defined, data 0x07:
  - mode 01 → parity bit 1.
  - mode 10 → parity bit 0.
  - Frame is 176 ticks; mode 11 → 160 ticks.
- NB_STOP=2, data 0xFF → stop high for 32 ticks; done pulse exactly 1 clock wide.
- i_tx_start pulsed with 0x12 mid-frame of 0xA5 → ignored; only 0xA5 is serialised; o_tx_busy=1 throughout the frame.
- i_tx_start held high with 0x3C then 0xC3 → done pulse, then o_tx low on the next clock; two correct frames with no idle gap.
- i_reset asserted at data bit 3 → o_tx=1 and o_tx_ready=1 immediately; no done pulse; the next 0x81 frame is correct.
